output_port_buffer: RTL

Per-port output stage of the 5-port router: one instance per output direction (L, N, S, E, W), placed between the switch crossbar output and the neighbour router's input link. Buffers flits forwarded by the switch in a small FIFO, drives them to the neighbour under the val/ret link handshake, and reports `full` back to the switch so that the arbiter stops granting this output.

---
 rtl/output_port_buffer.sv | 75 +++++++
 1 files changed

// File: rtl/output_port_buffer.sv
// Per-port router output stage: show-ahead FIFO draining to the neighbour link
// under val/ret handshake, with full back-pressure to the switch and sticky overflow.
module output_port_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  wr,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  val,
  input  logic                  ret,
  output logic                  ovf
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  wr_acc;
  logic                  rd_xfer;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign val      = (count_q != '0);
  assign Data_out = mem_q[rptr_q];
  assign ovf      = ovf_q;

  // Full blocks the write even when a transfer frees a slot this cycle.
  assign wr_acc  = wr && !full;
  assign rd_xfer = val && !ret;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q || (wr && full);
    if (wr_acc) begin
      mem_d[wptr_q] = Data_in;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (rd_xfer) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    case ({wr_acc, rd_xfer})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
